// File: rtl/lab1_pkg.sv
// Shared types and helpers for the push-button LED mode demo.
package lab1_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  localparam int unsigned LED_W = 4;

  // Milliseconds to clock cycles, never below one cycle.
  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    int unsigned cyc;
    cyc = freq / 32'd1000 * ms;
    return (cyc < 32'd1) ? 32'd1 : cyc;
  endfunction

endpackage

// File: rtl/lab1_led_mode_top_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debounce and a one-cycle
// pulse on each debounced press (0->1). Releases produce no pulse.
module btn_debounce
  import lab1_pkg::*;
#(
  parameter int unsigned DB_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB_CYC + 1);

  logic             sync1_q;
  logic             btn_s_q;
  logic             db_q;
  logic             db_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounced level follows btn_s only after it has differed for DB_CYC cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (btn_s_q != db_q) begin
      if (cnt_q == CNT_W'(DB_CYC - 1)) begin
        db_d  = btn_s_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = db_d & ~db_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      btn_s_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/lab1_led_mode_top.sv
// Push-button LED demo top: each debounced press advances the mode, which picks
// the LED pattern. Define LAB1_SHIFT_MODE_EN to build the running-light mode.
module lab1_led_mode_top
  import lab1_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 125_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned BLINK_HALF_MS = 250,
  parameter int unsigned SHIFT_MS      = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic [LED_W-1:0] leds
);

  localparam int unsigned DB_CYC = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned BL_CYC = ms_to_cycles(CLK_FREQ_HZ, BLINK_HALF_MS);
  localparam int unsigned BL_W   = $clog2(BL_CYC + 1);

  logic             press;
  mode_e            mode_q;
  mode_e            mode_d;
  logic             phase_q;
  logic             phase_d;
  logic [BL_W-1:0]  bl_cnt_q;
  logic [BL_W-1:0]  bl_cnt_d;
  logic [LED_W-1:0] leds_q;
  logic [LED_W-1:0] leds_d;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .press (press)
  );

  // Mode sequencing on each press pulse.
  always_comb begin
    mode_d = mode_q;
    if (press) begin
      case (mode_q)
        MODE_OFF:   mode_d = MODE_ON;
        MODE_ON:    mode_d = MODE_BLINK;
`ifdef LAB1_SHIFT_MODE_EN
        MODE_BLINK: mode_d = MODE_SHIFT;
`else
        MODE_BLINK: mode_d = MODE_OFF;
`endif
        default:    mode_d = MODE_OFF;
      endcase
    end
  end

  // Blink phase restarts high with a cleared counter whenever blink is not active.
  always_comb begin
    phase_d  = 1'b1;
    bl_cnt_d = '0;
    if (mode_q == MODE_BLINK) begin
      phase_d = phase_q;
      if (bl_cnt_q == BL_W'(BL_CYC - 1)) begin
        phase_d = ~phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + BL_W'(1);
      end
    end
  end

`ifdef LAB1_SHIFT_MODE_EN
  localparam int unsigned SH_CYC = ms_to_cycles(CLK_FREQ_HZ, SHIFT_MS);
  localparam int unsigned SH_W   = $clog2(SH_CYC + 1);

  logic [LED_W-1:0] pat_q;
  logic [LED_W-1:0] pat_d;
  logic [SH_W-1:0]  sh_cnt_q;
  logic [SH_W-1:0]  sh_cnt_d;

  // Running light restarts at 0001 whenever shift mode is not active.
  always_comb begin
    pat_d    = LED_W'(1);
    sh_cnt_d = '0;
    if (mode_q == MODE_SHIFT) begin
      pat_d = pat_q;
      if (sh_cnt_q == SH_W'(SH_CYC - 1)) begin
        pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
      end else begin
        sh_cnt_d = sh_cnt_q + SH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= LED_W'(1);
      sh_cnt_q <= '0;
    end else begin
      pat_q    <= pat_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end
`endif

  always_comb begin
    leds_d = '0;
    case (mode_q)
      MODE_OFF:   leds_d = '0;
      MODE_ON:    leds_d = '1;
      MODE_BLINK: leds_d = {LED_W{phase_q}};
`ifdef LAB1_SHIFT_MODE_EN
      MODE_SHIFT: leds_d = pat_q;
`else
      MODE_SHIFT: leds_d = '0;
`endif
      default:    leds_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_OFF;
      phase_q  <= 1'b1;
      bl_cnt_q <= '0;
      leds_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      bl_cnt_q <= bl_cnt_d;
      leds_q   <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_lab1_led_mode_top.sv
// Directed bench for lab1_led_mode_top at a 10 kHz model clock (DB=20, blink=30, shift=10 cycles).
module tb_lab1_led_mode_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [3:0] leds;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  lab1_led_mode_top #(
    .CLK_FREQ_HZ   (10_000),
    .DEBOUNCE_MS   (2),
    .BLINK_HALF_MS (3),
    .SHIFT_MS      (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press and release, long enough for both edges to debounce.
  task automatic press_clean();
    btn = 1'b1;
    step(30);
    btn = 1'b0;
    step(30);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    step(10);
    check_val("rst_leds", 32'(leds), 32'h0);
    check_val("rst_mode", 32'(dut.mode_q), 32'h0);
    rst_n = 1'b1;
    step(1);
    check_val("post_rst_leds", 32'(leds), 32'h0);
    check_val("post_rst_mode", 32'(dut.mode_q), 32'h0);

    // Short glitches must be ignored.
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    btn = 1'b1; step(1);
    btn = 1'b0; step(30);
    check_val("glitch_leds", 32'(leds), 32'h0);
    check_val("glitch_mode", 32'(dut.mode_q), 32'h0);

    // First press: mode at edge 23, leds at edge 24 after the rise.
    btn = 1'b1;
    step(22);
    check_val("p1_mode_e22", 32'(dut.mode_q), 32'h0);
    step(1);
    check_val("p1_mode_e23", 32'(dut.mode_q), 32'h1);
    check_val("p1_leds_e23", 32'(leds), 32'h0);
    step(1);
    check_val("p1_leds_e24", 32'(leds), 32'hf);
    step(176);
    check_val("hold_leds", 32'(leds), 32'hf);
    check_val("hold_mode", 32'(dut.mode_q), 32'h1);
    btn = 1'b0;
    step(60);
    check_val("release_leds", 32'(leds), 32'hf);
    check_val("release_mode", 32'(dut.mode_q), 32'h1);

    // Second press: blink, 30-cycle half period starting high.
    btn = 1'b1;
    step(23);
    check_val("p2_mode", 32'(dut.mode_q), 32'h2);
    step(1);
    check_val("blink_entry", 32'(leds), 32'hf);
    step(29);
    check_val("blink_e53", 32'(leds), 32'hf);
    step(1);
    check_val("blink_e54", 32'(leds), 32'h0);
    step(29);
    check_val("blink_e83", 32'(leds), 32'h0);
    step(1);
    check_val("blink_e84", 32'(leds), 32'hf);
    btn = 1'b0;
    step(40);

    // Third press: running light, or back to off when not built.
    btn = 1'b1;
    step(23);
`ifdef LAB1_SHIFT_MODE_EN
    check_val("p3_mode", 32'(dut.mode_q), 32'h3);
    step(1);
    check_val("shift_e24", 32'(leds), 32'h1);
    step(9);
    check_val("shift_e33", 32'(leds), 32'h1);
    step(1);
    check_val("shift_e34", 32'(leds), 32'h2);
    step(10);
    check_val("shift_e44", 32'(leds), 32'h4);
    step(10);
    check_val("shift_e54", 32'(leds), 32'h8);
    step(10);
    check_val("shift_wrap", 32'(leds), 32'h1);
    btn = 1'b0;
    step(40);
    press_clean();
    press_clean();
`else
    check_val("p3_mode", 32'(dut.mode_q), 32'h0);
    step(1);
    check_val("p3_leds", 32'(leds), 32'h0);
    step(40);
    check_val("p3_leds_late", 32'(leds), 32'h0);
    btn = 1'b0;
    step(40);
    press_clean();
`endif
    check_val("pre_blink_mode", 32'(dut.mode_q), 32'h1);

    // Enter blink again, then reset mid-blink with the button still held.
    btn = 1'b1;
    step(30);
    check_val("blink2_mode", 32'(dut.mode_q), 32'h2);
    check_val("blink2_leds", 32'(leds), 32'hf);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_leds", 32'(leds), 32'h0);
    check_val("async_rst_mode", 32'(dut.mode_q), 32'h0);
    step(5);
    rst_n = 1'b1;
    step(22);
    check_val("held_rst_mode_e22", 32'(dut.mode_q), 32'h0);
    check_val("held_rst_leds_e22", 32'(leds), 32'h0);
    step(1);
    check_val("held_rst_mode_e23", 32'(dut.mode_q), 32'h1);
    step(1);
    check_val("held_rst_leds_e24", 32'(leds), 32'hf);
    btn = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
